// File: rtl/lsu_if.sv
// Request/response, and memory strobe bundle between the memory stage, the LSU and the data memory.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault, mem_re, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_fault, mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one byte/half/word access at a time.
// Sub-word stores are done as read-modify-write, because memory only writes whole words.
module lsu #(
  parameter int unsigned ADDR_BITS = 9
) (
  input logic  clk,
  input logic  rst,
  lsu_if.slave bus
);

  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

  state_t          state;
  logic            ready_q;
  logic            re_q;
  logic            we_q;
  logic            resp_valid_q;
  logic            resp_fault_q;
  logic [DW-1:0]   resp_rdata_q;
  logic [DW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;

  logic            we_l;
  logic            uns_l;
  logic [1:0]      size_l;
  logic [1:0]      lane_l;
  logic [15:0]     wdata_l;

  logic            fault_c;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [DW-1:0]   load_c;
  logic [DW-1:0]   mask_c;
  logic [DW-1:0]   ins_c;
  logic [DW-1:0]   merge_c;

  // Request legality: alignment, size encoding and address range.
  always_comb begin
    fault_c = |bus.req_addr[DW-1:ADDR_BITS];
    case (bus.req_size)
      2'b01:   if (bus.req_addr[0]) fault_c = 1'b1;
      2'b10:   if (|bus.req_addr[1:0]) fault_c = 1'b1;
      2'b11:   fault_c = 1'b1;
      default: ;
    endcase
  end

  // Lane extraction/extension for loads and lane merge for sub-word stores.
  always_comb begin
    byte_v = 8'(bus.mem_rdata >> {lane_l, 3'b000});
    half_v = 16'(bus.mem_rdata >> {lane_l[1], 4'b0000});
    case (size_l)
      2'b00:   load_c = uns_l ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b01:   load_c = uns_l ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_c = bus.mem_rdata;
    endcase
    if (size_l == 2'b00) begin
      mask_c = 32'h0000_00FF << {lane_l, 3'b000};
      ins_c  = 32'(wdata_l[7:0]) << {lane_l, 3'b000};
    end else begin
      mask_c = 32'h0000_FFFF << {lane_l[1], 4'b0000};
      ins_c  = 32'(wdata_l) << {lane_l[1], 4'b0000};
    end
    merge_c = (bus.mem_rdata & ~mask_c) | (ins_c & mask_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ready_q      <= 1'b1;
      re_q         <= 1'b0;
      we_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      we_l         <= 1'b0;
      uns_l        <= 1'b0;
      size_l       <= '0;
      lane_l       <= '0;
      wdata_l      <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid && ready_q) begin
            if (fault_c) begin
              // Faults answer immediately and never reach memory.
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              we_l       <= bus.req_we;
              uns_l      <= bus.req_unsigned;
              size_l     <= bus.req_size;
              lane_l     <= bus.req_addr[1:0];
              wdata_l    <= bus.req_wdata[15:0];
              mem_addr_q <= {bus.req_addr[DW-1:2], 2'b00};
              ready_q    <= 1'b0;
              if (bus.req_we && bus.req_size == 2'b10) begin
                mem_wdata_q <= bus.req_wdata;
                we_q        <= 1'b1;
                state       <= WR;
              end else begin
                re_q  <= 1'b1;
                state <= RD;
              end
            end
          end
        end
        RD: begin
          re_q  <= 1'b0;
          state <= CAP;
        end
        CAP: begin
          if (we_l) begin
            mem_wdata_q <= merge_c;
            we_q        <= 1'b1;
            state       <= WR;
          end else begin
            resp_valid_q <= 1'b1;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= load_c;
            ready_q      <= 1'b1;
            state        <= IDLE;
          end
        end
        WR: begin
          we_q         <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_fault_q <= 1'b0;
          resp_rdata_q <= '0;
          ready_q      <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_fault = resp_fault_q;
  assign bus.mem_re     = re_q;
  // A write strobe left over from the cycle before reset must never reach memory.
  assign bus.mem_we     = we_q & ~rst;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: byte-array memory model with per-cycle expectations, directed cases plus random traffic.
module tb_lsu;

  logic clk;
  logic rst;
  lsu_if bus ();

  lsu #(.ADDR_BITS(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          re;
    bit          we;
    bit          rv;
    bit          fl;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  int          tests = 0;
  int          failed = 0;
  int          cyc = 0;
  int          busy_end = 0;
  bit          chk_en = 1'b0;
  bit          load_mem = 1'b0;
  exp_t        ex[int];
  exp_t        ce;
  logic [7:0]  ref_mem [512];
  logic [31:0] seed [128];
  logic [31:0] mem_words [128];

  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: whole-word writes, read data registered one cycle after re.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 128; i++) mem_words[i] <= seed[i];
    end else if (bus.mem_we) begin
      mem_words[bus.mem_addr[8:2]] <= bus.mem_wdata;
    end
    bus.mem_rdata <= bus.mem_re ? mem_words[bus.mem_addr[8:2]] : $urandom;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endfunction

  function automatic exp_t get_ex(int k);
    exp_t e;
    e = '{default: '0};
    if (ex.exists(k)) e = ex[k];
    return e;
  endfunction

  function automatic logic [31:0] ref_word(int wa);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) w |= 32'(ref_mem[wa + k]) << (8 * k);
    return w;
  endfunction

  // Reference: decides the whole future of an accepted request from byte-level rules.
  task automatic model_accept(input int c, input bit we, input logic [1:0] size, input bit uns,
                              input logic [31:0] a, input logic [31:0] wd,
                              output int rc, output logic [31:0] rv, output bit fl);
    int   nb;
    int   base;
    int   wa;
    exp_t e;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    fl = (size == 2'd3) || (size == 2'd1 && a % 2 != 0) || (size == 2'd2 && a % 4 != 0) ||
         (a >= 32'd512);
    rv = '0;
    if (fl) begin
      rc = c + 1;
    end else begin
      base = int'(a[8:0]);
      wa   = base - base % 4;
      if (!we) begin
        for (int k = 0; k < nb; k++) rv |= 32'(ref_mem[base + k]) << (8 * k);
        if (nb == 1 && !uns && rv[7])  rv |= 32'hFFFF_FF00;
        if (nb == 2 && !uns && rv[15]) rv |= 32'hFFFF_0000;
        e = get_ex(c + 1); e.re = 1'b1; e.maddr = 32'(wa); ex[c + 1] = e;
        rc = c + 3;
      end else begin
        for (int k = 0; k < nb; k++) ref_mem[base + k] = 8'(wd >> (8 * k));
        if (nb == 4) begin
          e = get_ex(c + 1); e.we = 1'b1; e.maddr = 32'(wa); e.wdata = ref_word(wa); ex[c + 1] = e;
          rc = c + 2;
        end else begin
          e = get_ex(c + 1); e.re = 1'b1; e.maddr = 32'(wa); ex[c + 1] = e;
          e = get_ex(c + 3); e.we = 1'b1; e.maddr = 32'(wa); e.wdata = ref_word(wa); ex[c + 3] = e;
          rc = c + 4;
        end
      end
    end
    e = get_ex(rc); e.rv = 1'b1; e.fl = fl; e.rdata = rv; ex[rc] = e;
    busy_end = rc;
  endtask

  // Reset in cycle r: everything planned after r is dropped, and no write may show in r itself.
  task automatic model_reset(input int r);
    int keys[$];
    foreach (ex[k]) if (k > r) keys.push_back(k);
    foreach (keys[i]) ex.delete(keys[i]);
    if (ex.exists(r)) ex[r].we = 1'b0;
    busy_end = r + 1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      ce = get_ex(cyc);
      chk("req_ready", 32'(bus.req_ready), 32'(cyc >= busy_end));
      chk("mem_re", 32'(bus.mem_re), 32'(ce.re));
      chk("mem_we", 32'(bus.mem_we), 32'(ce.we));
      chk("resp_valid", 32'(bus.resp_valid), 32'(ce.rv));
      if (ce.re || ce.we) chk("mem_addr", bus.mem_addr, ce.maddr);
      if (ce.we) chk("mem_wdata", bus.mem_wdata, ce.wdata);
      if (ce.rv) begin
        chk("resp_rdata", bus.resp_rdata, ce.rdata);
        chk("resp_fault", 32'(bus.resp_fault), 32'(ce.fl));
      end
    end
  end

  task automatic summary_and_finish();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  endtask

  // Present a request, wait (bounded) for acceptance, return accept cycle and model result.
  task automatic issue(input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int c, output int rc, output logic [31:0] rv, output bit fl);
    int n;
    bit got;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    n   = 0;
    got = 1'b0;
    while (!got) begin
      @(negedge clk);
      #1;
      if (bus.req_ready) begin
        got = 1'b1;
      end else begin
        n++;
        if (n > 20) begin
          tests++;
          failed++;
          $display("FAIL accept_timeout @cyc %0d: got no ready, expected ready within 20 cycles", cyc);
          summary_and_finish();
        end
      end
    end
    c = cyc;
    model_accept(c, we, size, uns, a, wd, rc, rv, fl);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int          c0, c1, rc0, rc1;
  logic [31:0] rv0, rv1, saved;
  bit          fl0, fl1;

  initial begin
    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    for (int i = 0; i < 128; i++) begin
      seed[i] = $urandom;
      for (int k = 0; k < 4; k++) ref_mem[4 * i + k] = 8'(seed[i] >> (8 * k));
    end
    load_mem = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    load_mem = 1'b0;
    chk_en   = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_outs", {bus.resp_rdata[29:0], bus.resp_valid, bus.resp_fault}, 32'd0);
    chk("reset_mem", bus.mem_addr | bus.mem_wdata | 32'(bus.mem_re) | 32'(bus.mem_we), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Word store then word load.
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, c0, rc0, rv0, fl0);
    chk("wstore_latency", 32'(rc0 - c0), 32'd2);
    idle(1);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, c0, rc0, rv0, fl0);
    chk("wload_value", rv0, 32'hDEAD_BEEF);
    chk("wload_latency", 32'(rc0 - c0), 32'd3);
    idle(3);

    // Byte RMW store into a known word.
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, c0, rc0, rv0, fl0);
    issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00A5, c0, rc0, rv0, fl0);
    chk("bstore_latency", 32'(rc0 - c0), 32'd4);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, c0, rc0, rv0, fl0);
    chk("bstore_merge", rv0, 32'h1122_A544);
    issue(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, c0, rc0, rv0, fl0);
    chk("lb_signed", rv0, 32'hFFFF_FFA5);
    issue(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, c0, rc0, rv0, fl0);
    chk("lb_unsigned", rv0, 32'h0000_00A5);
    issue(1'b1, 2'd1, 1'b0, 32'h12, 32'hFFFF_8001, c0, rc0, rv0, fl0);
    issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, c0, rc0, rv0, fl0);
    chk("lh_signed", rv0, 32'hFFFF_8001);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, c0, rc0, rv0, fl0);
    chk("hstore_merge", rv0, 32'h8001_A544);
    idle(2);

    // Faults.
    issue(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, c0, rc0, rv0, fl0);
    chk("fault_half", {31'(rc0 - c0), fl0}, {31'd1, 1'b1});
    issue(1'b1, 2'd2, 1'b0, 32'h16, 32'h1234, c0, rc0, rv0, fl0);
    chk("fault_word", {31'(rc0 - c0), fl0}, {31'd1, 1'b1});
    issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, c0, rc0, rv0, fl0);
    chk("fault_size", {31'(rc0 - c0), fl0}, {31'd1, 1'b1});
    issue(1'b1, 2'd2, 1'b0, 32'h200, 32'h55, c0, rc0, rv0, fl0);
    chk("fault_range", {31'(rc0 - c0), fl0}, {31'd1, 1'b1});
    idle(2);

    // Back-to-back: the second request is held and accepted in the response cycle.
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, c0, rc0, rv0, fl0);
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, c1, rc1, rv1, fl1);
    chk("b2b_accept", 32'(c1), 32'(rc0));
    chk("b2b_second", rv1, 32'h0000_0000 | {{24{ref_mem[19][7]}}, ref_mem[19]});
    idle(4);

    // Reset during RD of a byte store: the write is dropped.
    saved = ref_word(32);
    issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_005A, c0, rc0, rv0, fl0);
    for (int k = 0; k < 4; k++) ref_mem[32 + k] = 8'(saved >> (8 * k));
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    model_reset(cyc);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_mid_resp", {bus.resp_rdata[30:0], bus.resp_fault}, 32'd0);
    chk("rst_mid_mem", bus.mem_addr | bus.mem_wdata, 32'd0);
    idle(3);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, c0, rc0, rv0, fl0);
    chk("rst_mid_word", rv0, saved);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      int          r;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r  = $urandom_range(0, 15);
      if (r == 0) a = 32'd512 + 32'($urandom_range(0, 4095));
      else begin
        a = 32'($urandom_range(0, 511));
        if (r > 4 && sz == 2'd1) a[0] = 1'b0;
        if (r > 4 && sz == 2'd2) a[1:0] = 2'b00;
      end
      issue(1'($urandom), sz, 1'($urandom), a, $urandom, c0, rc0, rv0, fl0);
      r = $urandom_range(0, 2);
      if (r != 0) idle(r);
    end
    idle(6);

    for (int i = 0; i < 128; i++) chk("final_mem", mem_words[i], ref_word(4 * i));
    summary_and_finish();
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the pipeline's memory stage and the byte-addressed data `memory` block. It accepts one byte, halfword or word access at a time over a valid/ready handshake. It issues word-aligned `re`/`we` strobes to memory, performing read-modify-write for sub-word stores since memory writes whole words. Load data is returned lane-extracted and sign- or zero-extended, and misaligned or out-of-range accesses are flagged as faults without touching memory.

## Interface
- `ADDR_BITS`, 9: byte-address width of the backing memory; valid addresses are 0 .. 2^ADDR_BITS-1.
- `clk`  in  1  clock; every register updates on the rising edge.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  high only in IDLE; a request is accepted on an edge where valid&ready.
- `req_we_i`  in  1  1 = store, 0 = load.
- `req_size_i`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned_i`  in  1  loads only: zero-extend when 1, sign-extend when 0.
- `req_addr_i`  in  32  byte address.
- `req_wdata_i`  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- `resp_valid_o`  out  1  one-cycle completion pulse.
- `resp_rdata_o`  out  32  extended load data; 0 for stores and faults.
- `resp_fault_o`  out  1  qualified by resp_valid_o.
- `mem_re_o`, `mem_we_o`  out  1  memory read/write strobes.
- `mem_addr_o`  out  32  latched address with bits [1:0] forced to 0.
- `mem_wdata_o`  out  32  word to write.
- `mem_rdata_i`  in  32  memory read data, valid the cycle after mem_re_o.

## Operation
- The request is latched on accept; req_* inputs need not hold afterwards.
- States: IDLE, RD, CAP, WR.
- Fault at accept: size=11, half with addr[0]=1, word with addr[1:0]!=0, or addr >= 2^ADDR_BITS.
  - A faulting request stays in IDLE.
  - The next cycle carries resp_valid_o=1, resp_fault_o=1, resp_rdata_o=0.
  - No memory strobe is issued.
- Load: IDLE -> RD -> CAP -> IDLE.
- Word store: IDLE -> WR -> IDLE.
- Byte/half store: IDLE -> RD -> CAP -> WR -> IDLE.
- In RD: mem_re_o=1.
- In CAP: mem_rdata_i is sampled; mem_rdata_i is ignored in every other state.
- Load in CAP, with lane = addr[1:0]:
  - Byte = rdata[8*lane +: 8].
  - Half = rdata[16*lane[1] +: 16].
  - Extend per req_unsigned_i, register the result into resp_rdata_o, and pulse resp_valid_o.
- Sub-word store in CAP:
  - Register the merged word: rdata with the byte at lane, or the half at lane[1], replaced by the wdata.
  - Unaddressed bytes are preserved.
- In WR: mem_we_o=1 and mem_wdata_o = merged word, or req_wdata for a word store. resp_valid_o pulses at the WR exit edge.
- Outside RD/WR: mem_re_o=mem_we_o=0.
- mem_addr_o and mem_wdata_o hold their last value; they are 0 after reset.
- mem_we_o is gated by ~rst, so no write is ever issued in a reset cycle.

## Timing
- Edge E0 is the accept edge.
- Load: resp_valid_o high in the cycle after E2; throughput is 1 per 3 cycles.
- Word store: memory commits at E1; resp_valid_o high in the cycle after E1.
- Sub-word store: commits at E3; resp_valid_o high in the cycle after E3.
- Fault: resp_valid_o high in the cycle after E0.
- resp_valid_o is high for exactly one cycle. In that cycle the FSM is already in IDLE, so req_ready_o=1 and a back-to-back accept is legal.
- resp_rdata_o and resp_fault_o hold until the next response.
- Reset values: state IDLE; req_ready_o=1; all other outputs 0.
- rst in any state returns to IDLE at that edge. The in-flight access is dropped with no response, and a pending RMW write is never issued.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> one mem_we_o cycle with addr 0x10; load resp 0xDEADBEEF on the 3rd cycle after accept, fault=0.
- Byte store 0xA5 @0x11 over word 0x11223344 -> RD, CAP, WR sequence; word @0x10 becomes 0x1122A544.
- Extension checks:
  - Signed byte load @0x11 -> 0xFFFFFFA5; unsigned -> 0x000000A5.
  - Half store 0x8001 @0x12, then signed half load @0x12 -> 0xFFFF8001.
- Faults:
  - Half @0x13, word @0x16, size=11, addr 0x200 -> fault=1 in the cycle after accept.
  - mem_re_o/mem_we_o never assert.
- Back-to-back: a second request is held valid while the first completes; it is accepted in the resp_valid_o cycle and both responses are correct.
- Reset during RD of a sub-word store:
  - No mem_we_o ever pulses and no resp_valid_o.
  - Memory word is unchanged.
  - All outputs return to reset values next cycle.
